// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one external memory port between the CPU data path, instruction
// fetch and a DMA master. One transaction is in flight at a time. Priority is
// data > fetch > DMA. A starvation counter forces DMA through after
// STARVE_LIMIT consecutive data/fetch grants taken while DMA was waiting. A
// response timeout aborts a transaction stuck on the memory side and reports
// it through err. Every output comes straight from a flop.

module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,    // 1..15
    parameter int unsigned TIMEOUT      = 255   // 1..255
) (
    input  logic        clk,
    input  logic        rst,        // asynchronous, active-low
    // CPU data requester
    input  logic        d_req,
    input  logic        d_we,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_ack,
    // instruction fetch requester (read only)
    input  logic        f_req,
    input  logic [15:0] f_addr,
    output logic        f_ack,
    // DMA / peripheral master
    input  logic        x_req,
    input  logic        x_we,
    input  logic [15:0] x_addr,
    input  logic [15:0] x_wdata,
    output logic        x_ack,
    // shared response
    output logic [15:0] r_data,
    output logic        err,
    // memory controller side
    output logic        m_req,
    output logic        m_we,
    output logic        m_instr,
    output logic [15:0] m_addr,
    output logic [15:0] m_wdata,
    input  logic [15:0] m_rdata,
    input  logic        m_busy,
    input  logic        m_cack,
    input  logic        m_ready,
    // current owner
    output logic [1:0]  grant
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] GNT_NONE  = 2'd0;
    localparam logic [1:0] GNT_DATA  = 2'd1;
    localparam logic [1:0] GNT_FETCH = 2'd2;
    localparam logic [1:0] GNT_DMA   = 2'd3;

    localparam logic [3:0] STARVE_LIMIT_C = STARVE_LIMIT[3:0];
    localparam logic [7:0] TIMEOUT_C      = TIMEOUT[7:0];

    state_t      state_r;
    logic [3:0]  starve_cnt_r;
    logic [7:0]  tmo_cnt_r;

    logic [1:0]  win_s;
    logic [2:0]  ack_hot_s;     // {x, f, d}
    logic [7:0]  tmo_next_s;
    logic        tmo_hit_s;
    logic        starve_s;

    // Winner selection for the IDLE decision; a starved DMA overrides priority.
    always_comb begin
        win_s    = GNT_NONE;
        starve_s = (starve_cnt_r == STARVE_LIMIT_C);
        if (x_req && starve_s) begin
            win_s = GNT_DMA;
        end else if (d_req) begin
            win_s = GNT_DATA;
        end else if (f_req) begin
            win_s = GNT_FETCH;
        end else if (x_req) begin
            win_s = GNT_DMA;
        end else begin
            win_s = GNT_NONE;
        end
    end

    // One-hot acknowledge vector for the requester that currently owns the port.
    always_comb begin
        ack_hot_s = 3'b000;
        case (grant)
            GNT_DATA:  ack_hot_s = 3'b001;
            GNT_FETCH: ack_hot_s = 3'b010;
            GNT_DMA:   ack_hot_s = 3'b100;
            default:   ack_hot_s = 3'b000;
        endcase
    end

    // Timeout fires on the cycle that would bring the count up to TIMEOUT, so
    // the transaction spends exactly TIMEOUT cycles in ISSUE+WAIT.
    always_comb begin
        tmo_next_s = tmo_cnt_r + 8'd1;
        if (tmo_next_s == TIMEOUT_C) begin
            tmo_hit_s = 1'b1;
        end else begin
            tmo_hit_s = 1'b0;
        end
    end

    // Arbiter FSM: grant, command issue, response capture and ack generation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            starve_cnt_r <= 4'd0;
            tmo_cnt_r    <= 8'd0;
            d_ack        <= 1'b0;
            f_ack        <= 1'b0;
            x_ack        <= 1'b0;
            r_data       <= 16'h0000;
            err          <= 1'b0;
            m_req        <= 1'b0;
            m_we         <= 1'b0;
            m_instr      <= 1'b0;
            m_addr       <= 16'h0000;
            m_wdata      <= 16'h0000;
            grant        <= GNT_NONE;
        end else begin
            // acks are single-cycle pulses; only the transition into DONE raises one
            d_ack <= 1'b0;
            f_ack <= 1'b0;
            x_ack <= 1'b0;

            case (state_r)
                ST_IDLE: begin
                    if (!x_req) begin
                        starve_cnt_r <= 4'd0;
                    end
                    if (!m_busy && (win_s != GNT_NONE)) begin
                        grant     <= win_s;
                        m_req     <= 1'b1;
                        tmo_cnt_r <= 8'd0;
                        state_r   <= ST_ISSUE;
                        case (win_s)
                            GNT_DATA: begin
                                m_we    <= d_we;
                                m_instr <= 1'b0;
                                m_addr  <= d_addr;
                                m_wdata <= d_wdata;
                                if (x_req && (starve_cnt_r < STARVE_LIMIT_C)) begin
                                    starve_cnt_r <= starve_cnt_r + 4'd1;
                                end
                            end
                            GNT_FETCH: begin
                                m_we    <= 1'b0;
                                m_instr <= 1'b1;
                                m_addr  <= f_addr;
                                m_wdata <= 16'h0000;
                                if (x_req && (starve_cnt_r < STARVE_LIMIT_C)) begin
                                    starve_cnt_r <= starve_cnt_r + 4'd1;
                                end
                            end
                            GNT_DMA: begin
                                m_we         <= x_we;
                                m_instr      <= 1'b0;
                                m_addr       <= x_addr;
                                m_wdata      <= x_wdata;
                                starve_cnt_r <= 4'd0;
                            end
                            default: begin
                                m_we    <= 1'b0;
                                m_instr <= 1'b0;
                            end
                        endcase
                    end
                end

                ST_ISSUE: begin
                    if (m_cack && (m_we || m_ready)) begin
                        // write accepted, or read accepted with data in the same cycle
                        m_req                 <= 1'b0;
                        r_data                <= m_we ? 16'h0000 : m_rdata;
                        err                   <= 1'b0;
                        {x_ack, f_ack, d_ack} <= ack_hot_s;
                        state_r               <= ST_DONE;
                    end else if (tmo_hit_s) begin
                        m_req                 <= 1'b0;
                        r_data                <= 16'h0000;
                        err                   <= 1'b1;
                        {x_ack, f_ack, d_ack} <= ack_hot_s;
                        state_r               <= ST_DONE;
                    end else if (m_cack) begin
                        // read accepted, data still to come
                        m_req     <= 1'b0;
                        tmo_cnt_r <= tmo_next_s;
                        state_r   <= ST_WAIT;
                    end else begin
                        tmo_cnt_r <= tmo_next_s;
                    end
                end

                ST_WAIT: begin
                    if (m_ready) begin
                        r_data                <= m_rdata;
                        err                   <= 1'b0;
                        {x_ack, f_ack, d_ack} <= ack_hot_s;
                        state_r               <= ST_DONE;
                    end else if (tmo_hit_s) begin
                        r_data                <= 16'h0000;
                        err                   <= 1'b1;
                        {x_ack, f_ack, d_ack} <= ack_hot_s;
                        state_r               <= ST_DONE;
                    end else begin
                        tmo_cnt_r <= tmo_next_s;
                    end
                end

                ST_DONE: begin
                    // response was visible for exactly this cycle; release the port
                    grant   <= GNT_NONE;
                    r_data  <= 16'h0000;
                    err     <= 1'b0;
                    state_r <= ST_IDLE;
                end

                default: begin
                    m_req   <= 1'b0;
                    grant   <= GNT_NONE;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed bench for mem_arbiter (STARVE_LIMIT=4, TIMEOUT=8). Single
// transactions come from a table of hand-computed vectors; priority spacing,
// starvation, busy back-pressure and mid-transaction reset are hand sequences.

module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        d_req, d_we, f_req, x_req, x_we;
    logic [15:0] d_addr, d_wdata, f_addr, x_addr, x_wdata;
    logic        d_ack, f_ack, x_ack;
    logic [15:0] r_data;
    logic        err;
    logic        m_req, m_we, m_instr;
    logic [15:0] m_addr, m_wdata, m_rdata;
    logic        m_busy, m_cack, m_ready;
    logic [1:0]  grant;

    int pass_cnt = 0;
    int total_cnt = 0;

    mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
        .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack),
        .x_req(x_req), .x_we(x_we), .x_addr(x_addr), .x_wdata(x_wdata), .x_ack(x_ack),
        .r_data(r_data), .err(err),
        .m_req(m_req), .m_we(m_we), .m_instr(m_instr), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_busy(m_busy), .m_cack(m_cack), .m_ready(m_ready),
        .grant(grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        d_req;  logic d_we;  logic [15:0] d_addr; logic [15:0] d_wdata;
        logic        f_req;  logic [15:0] f_addr;
        logic        x_req;  logic x_we;  logic [15:0] x_addr; logic [15:0] x_wdata;
        int          cack_dly;            // ISSUE cycle index of the cack pulse (99 = never)
        int          rdy_dly;             // cycle index of the ready pulse (99 = never)
        logic [15:0] rdata;
        logic [1:0]  e_grant; logic e_we; logic e_instr;
        logic [15:0] e_addr;  logic [15:0] e_wdata;
        logic [2:0]  e_acks;              // {x, f, d}
        logic [15:0] e_rdata; logic e_err;
        int          e_lat;               // ack cycle, cycle 0 = request sampled
    } vec_t;

    vec_t tbl[12];

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [63:0] outs_all();
        return {7'd0, d_ack, f_ack, x_ack, r_data, err, m_req, m_we, m_instr,
                m_addr, m_wdata, grant};
    endfunction

    task automatic drop_all();
        d_req = 1'b0; f_req = 1'b0; x_req = 1'b0;
        m_cack = 1'b0; m_ready = 1'b0;
    endtask

    // Entered in an IDLE cycle just after a rising edge.
    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        bit seen;
        lat = 0;
        seen = 1'b0;
        d_req = v.d_req; d_we = v.d_we; d_addr = v.d_addr; d_wdata = v.d_wdata;
        f_req = v.f_req; f_addr = v.f_addr;
        x_req = v.x_req; x_we = v.x_we; x_addr = v.x_addr; x_wdata = v.x_wdata;
        m_cack = 1'b0; m_ready = 1'b0; m_rdata = 16'hDEAD;
        @(posedge clk); #1;
        for (int k = 1; k <= 20 && !seen; k++) begin
            m_cack  = (k - 1 == v.cack_dly);
            m_ready = (k - 1 == v.rdy_dly);
            m_rdata = (k - 1 == v.rdy_dly) ? v.rdata : 16'hDEAD;
            @(negedge clk);
            if (k == 1) begin
                check({tag, " grant"}, {62'd0, grant}, {62'd0, v.e_grant});
                check({tag, " addr"}, {47'd0, m_req, m_addr}, {47'd0, 1'b1, v.e_addr});
                check({tag, " we/instr/wdata"}, {46'd0, m_we, m_instr, m_wdata},
                      {46'd0, v.e_we, v.e_instr, v.e_wdata});
            end
            if (d_ack || f_ack || x_ack) begin
                seen = 1'b1;
                lat = k;
                check({tag, " acks"}, {61'd0, x_ack, f_ack, d_ack}, {61'd0, v.e_acks});
                check({tag, " r_data/err"}, {47'd0, err, r_data}, {47'd0, v.e_err, v.e_rdata});
                check({tag, " m_req low at ack"}, {63'd0, m_req}, 64'd0);
            end
            @(posedge clk); #1;
        end
        check({tag, " ack latency"}, 64'(lat), 64'(v.e_lat));
        drop_all();
        @(negedge clk);
        check({tag, " idle after"}, {59'd0, grant, m_req, d_ack | f_ack | x_ack, err}, 64'd0);
        @(posedge clk); #1;
    endtask

    // Entered in an IDLE cycle with requests already driven; memory answers at once.
    task automatic serve(input logic [1:0] exp_g, input string tag);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            if (m_req) begin
                got = 1'b1;
                check({tag, " grant"}, {62'd0, grant}, {62'd0, exp_g});
            end
        end
        check({tag, " issued"}, {63'd0, got}, 64'd1);
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            if (d_ack || f_ack || x_ack) begin
                got = 1'b1;
                check({tag, " acks"}, {61'd0, x_ack, f_ack, d_ack},
                      64'(3'b001 << (exp_g - 2'd1)));
            end
        end
        check({tag, " acked"}, {63'd0, got}, 64'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] starve_exp [6];
        //            d  we addr      wdata     f  faddr     x  xwe xaddr    xwdata    cack rdy rdata     grant we instr addr     wdata     acks    rdata     err lat
        tbl[0]  = '{1'b0,1'b0,16'h0000,16'h0000, 1'b1,16'h1234, 1'b0,1'b0,16'h0000,16'h0000, 0, 2, 16'hBEEF, 2'd2,1'b0,1'b1,16'h1234,16'h0000,3'b010,16'hBEEF,1'b0,4};
        tbl[1]  = '{1'b1,1'b1,16'h0010,16'h5A5A, 1'b1,16'h0020, 1'b0,1'b0,16'h0000,16'h0000, 0,99, 16'h0000, 2'd1,1'b1,1'b0,16'h0010,16'h5A5A,3'b001,16'h0000,1'b0,2};
        tbl[2]  = '{1'b1,1'b0,16'h0200,16'hAAAA, 1'b0,16'h0000, 1'b0,1'b0,16'h0000,16'h0000, 0, 0, 16'h1111, 2'd1,1'b0,1'b0,16'h0200,16'hAAAA,3'b001,16'h1111,1'b0,2};
        tbl[3]  = '{1'b0,1'b0,16'h0000,16'h0000, 1'b0,16'h0000, 1'b1,1'b1,16'h8000,16'hC0DE, 2,99, 16'h0000, 2'd3,1'b1,1'b0,16'h8000,16'hC0DE,3'b100,16'h0000,1'b0,4};
        tbl[4]  = '{1'b0,1'b0,16'h0000,16'h0000, 1'b0,16'h0000, 1'b1,1'b0,16'h8002,16'h0BAD, 1, 3, 16'h7E57, 2'd3,1'b0,1'b0,16'h8002,16'h0BAD,3'b100,16'h7E57,1'b0,5};
        tbl[5]  = '{1'b1,1'b0,16'h0300,16'h3333, 1'b1,16'h0304, 1'b1,1'b1,16'h8004,16'h4444, 0, 1, 16'h2222, 2'd1,1'b0,1'b0,16'h0300,16'h3333,3'b001,16'h2222,1'b0,3};
        tbl[6]  = '{1'b1,1'b1,16'h0400,16'h1357, 1'b0,16'h0000, 1'b0,1'b0,16'h0000,16'h0000,99,99, 16'h0000, 2'd1,1'b1,1'b0,16'h0400,16'h1357,3'b001,16'h0000,1'b1,9};
        tbl[7]  = '{1'b0,1'b0,16'h0000,16'h0000, 1'b1,16'h0042, 1'b0,1'b0,16'h0000,16'h0000, 1, 1, 16'h4E4F, 2'd2,1'b0,1'b1,16'h0042,16'h0000,3'b010,16'h4E4F,1'b0,3};
        tbl[8]  = '{1'b1,1'b0,16'h0500,16'h2468, 1'b0,16'h0000, 1'b0,1'b0,16'h0000,16'h0000, 0,99, 16'h0000, 2'd1,1'b0,1'b0,16'h0500,16'h2468,3'b001,16'h0000,1'b1,9};
        tbl[9]  = '{1'b0,1'b0,16'h0000,16'h0000, 1'b0,16'h0000, 1'b1,1'b0,16'h8010,16'h1111, 5, 5, 16'hABCD, 2'd3,1'b0,1'b0,16'h8010,16'h1111,3'b100,16'hABCD,1'b0,7};
        tbl[10] = '{1'b0,1'b0,16'h0000,16'h0000, 1'b1,16'h0777, 1'b0,1'b0,16'h0000,16'h0000, 2, 0, 16'h9999, 2'd2,1'b0,1'b1,16'h0777,16'h0000,3'b010,16'h0000,1'b1,9};
        tbl[11] = '{1'b0,1'b0,16'h0000,16'h0000, 1'b1,16'h0100, 1'b1,1'b1,16'h8020,16'h2222, 0, 0, 16'h5555, 2'd2,1'b0,1'b1,16'h0100,16'h0000,3'b010,16'h5555,1'b0,2};

        // reset held with every requester active
        rst = 1'b0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0001; d_wdata = 16'h00FF;
        f_req = 1'b1; f_addr = 16'h0002;
        x_req = 1'b1; x_we = 1'b1; x_addr = 16'h0003; x_wdata = 16'h0004;
        m_busy = 1'b0; m_cack = 1'b1; m_ready = 1'b1; m_rdata = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("reset outputs %0d", i), outs_all(), 64'd0);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("first grant after reset", {61'd0, m_req, grant}, {61'd0, 1'b1, 2'd1});
        @(negedge clk);
        check("first ack after reset", {61'd0, x_ack, f_ack, d_ack}, 64'd1);
        @(posedge clk); #1;
        drop_all();
        @(posedge clk); #1;

        // single-transaction vectors
        for (int i = 0; i < 12; i++) begin
            run_vec(tbl[i], $sformatf("v%0d", i));
        end

        // data and fetch together: fetch follows three cycles after data
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0010; d_wdata = 16'h5A5A;
        f_req = 1'b1; f_addr = 16'h0030;
        m_cack = 1'b1; m_ready = 1'b1; m_rdata = 16'h6F6F;
        @(negedge clk);
        @(negedge clk);
        check("prio data cmd", {46'd0, grant, m_we, m_wdata}, {46'd0, 2'd1, 1'b1, 16'h5A5A});
        @(negedge clk);
        check("prio d_ack", {61'd0, x_ack, f_ack, d_ack}, 64'd1);
        @(posedge clk); #1;
        d_req = 1'b0;
        @(negedge clk);
        check("prio gap grant", {62'd0, grant}, 64'd0);
        @(negedge clk);
        check("prio fetch cmd", {45'd0, grant, m_instr, m_addr}, {45'd0, 2'd2, 1'b1, 16'h0030});
        @(negedge clk);
        check("prio f_ack", {45'd0, x_ack, f_ack, d_ack, r_data}, {45'd0, 3'b010, 16'h6F6F});
        @(posedge clk); #1;
        drop_all();
        @(posedge clk); #1;

        // starvation: DMA held while data and fetch alternate
        starve_exp = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd3, 2'd2};
        x_req = 1'b1; x_we = 1'b0; x_addr = 16'h9000; x_wdata = 16'h0000;
        d_we = 1'b1; d_addr = 16'h0050; d_wdata = 16'h0055; f_addr = 16'h0060;
        m_cack = 1'b1; m_ready = 1'b1; m_rdata = 16'h1234;
        for (int r = 0; r < 6; r++) begin
            d_req = (r % 2 == 0);
            f_req = (r % 2 == 1);
            serve(starve_exp[r], $sformatf("starve r%0d", r));
        end
        drop_all();
        @(posedge clk); #1;

        // memory busy holds off the grant; cack/ready with m_req low are ignored
        m_busy = 1'b1; m_cack = 1'b1; m_ready = 1'b1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0ABC; d_wdata = 16'h0F0F;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("busy hold %0d", i), {59'd0, m_req, grant, d_ack, err}, 64'd0);
        end
        @(posedge clk); #1;
        m_busy = 1'b0;
        serve(2'd1, "busy release");
        drop_all();
        @(posedge clk); #1;

        // reset asserted while waiting for read data
        f_req = 1'b1; f_addr = 16'h2222; m_cack = 1'b1; m_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        m_cack = 1'b0;
        check("wait state", {61'd0, m_req, grant}, {61'd0, 1'b0, 2'd2});
        #2;
        rst = 1'b0;
        #1;
        check("async reset in WAIT", outs_all(), 64'd0);
        m_ready = 1'b1; m_rdata = 16'h7777;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check($sformatf("no ack in reset %0d", i), outs_all(), 64'd0);
        end
        drop_all();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // reset asserted while the command is on the bus
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h3333; m_cack = 1'b0;
        @(posedge clk); #1;
        check("issue m_req", {63'd0, m_req}, 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check("async reset in ISSUE", outs_all(), 64'd0);
        drop_all();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        run_vec(tbl[0], "recover");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single external memory port between three requesters: the CPU data path (load/store), the instruction fetch unit, and a DMA/peripheral master. It sits between the core and the memory controller. It serialises requests into one outstanding memory transaction at a time and returns read data with a one-cycle acknowledge to the winning requester. Priority is data > fetch > DMA, with a starvation guard for DMA and a response timeout that prevents memory-side deadlock.

## Interface
Parameters:
- STARVE_LIMIT, 4, consecutive data/fetch grants while x_req is pending before DMA is forced to win (1..15)
- TIMEOUT, 255, cycles a transaction may stay in ISSUE+WAIT before it is aborted (1..255)

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  reset; asynchronous, active-low
- d_req, d_we  in  1  CPU data request / write enable
- d_addr, d_wdata  in  16  CPU data address / write data
- d_ack  out  1  one-cycle completion pulse to CPU data
- f_req  in  1  fetch request (read only)
- f_addr  in  16  fetch address
- f_ack  out  1  one-cycle completion pulse to fetch
- x_req, x_we  in  1  DMA request / write enable
- x_addr, x_wdata  in  16  DMA address / write data
- x_ack  out  1  one-cycle completion pulse to DMA
- r_data  out  16  read data; valid only in the ack cycle
- err  out  1  timeout flag; valid only in the ack cycle
- m_req  out  1  memory command valid
- m_we  out  1  memory write
- m_instr  out  1  high when the transaction is a fetch
- m_addr, m_wdata  out  16  memory address / write data
- m_rdata  in  16  memory read data
- m_busy  in  1  memory cannot accept a command
- m_cack  in  1  command accepted (sampled while m_req=1)
- m_ready  in  1  read data valid on m_rdata
- grant  out  2  current owner: 0 none, 1 data, 2 fetch, 3 DMA

## Operation
- States: IDLE, ISSUE, WAIT, DONE. All outputs are registered.
- IDLE: if m_busy=0 and any req is high, choose a winner. Priority order is data, then fetch, then DMA. When starve_cnt == STARVE_LIMIT and x_req=1, DMA wins instead. Latch the winner's we/addr/wdata into the m_* registers, set grant, and go to ISSUE. If m_busy=1, stay in IDLE and make no grant.
- ISSUE: m_req=1 and the command is held stable. When m_cack=1:
  - write: go to DONE.
  - read with m_ready=0: go to WAIT.
  - read with m_ready=1 in the same cycle: capture m_rdata and go to DONE.
  - m_req drops in the cycle after the cack.
- WAIT: when m_ready=1, capture m_rdata into r_data and go to DONE.
- DONE: pulse the ack for the granted requester for exactly one cycle. r_data and err are valid in this cycle. Then grant=0, go to IDLE.
- Fetch always has m_we=0 and m_instr=1. Data and DMA have m_instr=0.
- Starvation counter (4 bits):
  - increments on each data/fetch grant made while x_req=1;
  - clears on a DMA grant, or in IDLE when x_req=0;
  - saturates at STARVE_LIMIT.
- Timeout counter (8 bits):
  - clears on entry to ISSUE and increments every cycle in ISSUE/WAIT;
  - when it reaches TIMEOUT: go to DONE with err=1, r_data=0x0000, m_req dropped.
- Requesters hold req and their payload until ack. After ack, the next cycle's req is treated as a new request.
- If req drops mid-transaction, the transaction still completes and ack still pulses.
- Fetch starvation by data is not guarded; the core never issues back-to-back data accesses without a fetch.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, and every output is 0: acks, r_data, err, m_req, m_we, m_instr, m_addr, m_wdata, grant. Both counters are 0. Reset mid-transaction drops m_req immediately; no ack is produced.
- Write with immediate cack: req sampled at cycle 0 → m_req high in cycle 1 → ack in cycle 2 → IDLE in cycle 3.
- Read with cack and ready in the same cycle: ack in cycle 2. Each extra wait cycle on cack or ready adds one cycle.
- Minimum spacing between grants is 3 cycles. There is never more than one outstanding transaction.
- Simultaneous d_req, f_req, x_req with starve_cnt<STARVE_LIMIT → data wins. Fetch and DMA stay pending and are not acked.
- m_ready asserted while not in WAIT or ISSUE is ignored. m_cack asserted while m_req=0 is ignored.
- A timeout abort resolves at exactly TIMEOUT cycles after ISSUE entry; the ack follows in DONE.

## Test plan
- Reset: hold rst=0 with all reqs high → all outputs 0, grant=0. Release rst → the first grant is data.
- Read latency: f_req with f_addr=0x1234; memory gives cack in cycle 1 and ready with m_rdata=0xBEEF in cycle 3 → m_instr=1, m_addr=0x1234, f_ack with r_data=0xBEEF in cycle 4, err=0.
- Priority: d_req (write 0x0010←0x5A5A) and f_req together, immediate cack → d_ack first with m_we=1 and m_wdata=0x5A5A, then f granted 3 cycles later.
- Starvation: x_req held while d_req/f_req alternate continuously, STARVE_LIMIT=4 → the 5th grant goes to DMA (grant=3), and the counter clears.
- Timeout: TIMEOUT=8, memory never asserts cack → m_req drops after 8 cycles, d_ack with err=1 and r_data=0x0000. The next request is served normally.
- Busy and reset: m_busy=1 with d_req high → no m_req for 10 cycles, then it proceeds once m_busy=0. Assert rst during WAIT → no ack, all outputs 0 asynchronously.
